// File: rtl/ctrl_pkg.sv
// Shared definitions for the three-master shared-access controller and its requesters.
package ctrl_pkg;

  localparam int M1 = 0;
  localparam int M2 = 1;
  localparam int M3 = 2;

  typedef logic [1:0] accmodule_t;

  localparam accmodule_t ACC_NONE = 2'd0;
  localparam accmodule_t ACC_M1   = 2'd1;
  localparam accmodule_t ACC_M2   = 2'd2;
  localparam accmodule_t ACC_M3   = 2'd3;

  typedef enum logic [2:0] {IDLE, REQ, XFER, SUSP, DONE} req_state_e;

endpackage

// File: rtl/access_requester_array.sv
// Three requesters (M1..M3) whose req/done bits form the controller's req[2:0]/done[2:0].
module access_requester_array
  import ctrl_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            start,
  input  logic [2:0][LEN_W-1:0] len,
  input  logic [2:0]            abort,
  input  accmodule_t            accmodule,
  output logic [2:0]            req,
  output logic [2:0]            done,
  output logic [2:0]            busy,
  output logic [2:0]            granted,
  output logic [2:0][LEN_W-1:0] remaining,
  output logic [2:0][7:0]       preempt_cnt,
  output logic [2:0]            starved
);

  for (genvar i = 0; i < 3; i++) begin : g_req
    access_requester #(
      .MODULE_ID   (i),
      .LEN_W       (LEN_W),
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_req (
      .clk        (clk),
      .reset      (reset),
      .start      (start[i]),
      .len        (len[i]),
      .abort      (abort[i]),
      .accmodule  (accmodule),
      .req        (req[i]),
      .done       (done[i]),
      .busy       (busy[i]),
      .granted    (granted[i]),
      .remaining  (remaining[i]),
      .preempt_cnt(preempt_cnt[i]),
      .starved    (starved[i])
    );
  end

endmodule

// File: rtl/access_requester.sv
// Per-master initiator: requests the shared resource, counts granted beats,
// survives preemption and pulses done once the command is complete.
//
// state | meaning
// IDLE  | no command; waits for start with a non-zero length
// REQ   | requesting, not yet granted since the command started
// XFER  | granted; one beat per granted cycle
// SUSP  | preempted mid-command; request held, remaining preserved
// DONE  | one-cycle completion pulse, request dropped
module access_requester
  import ctrl_pkg::*;
#(
  parameter int MODULE_ID    = 0,
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  accmodule_t       accmodule,
  output logic             req,
  output logic             done,
  output logic             busy,
  output logic             granted,
  output logic [LEN_W-1:0] remaining,
  output logic [7:0]       preempt_cnt,
  output logic             starved
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam accmodule_t MY_ACC = accmodule_t'(MODULE_ID + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  req_state_e        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [7:0]        pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              granted_q, granted_d;
  logic              starved_q, starved_d;
  logic              g;

  assign g = (accmodule == MY_ACC);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d = REQ;
          rem_d   = len;
          pc_d    = 8'd0;
          wait_d  = '0;
          req_d   = 1'b1;
        end
      end
      REQ, XFER, SUSP: begin
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
          wait_d  = '0;
          req_d   = 1'b0;
        end else if (g) begin
          wait_d = '0;
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
            rem_d   = '0;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = XFER;
            rem_d   = rem_q - LEN_W'(1);
          end
        end else if (state_q == XFER) begin
          state_d = SUSP;
          if (pc_q != 8'hFF) pc_d = pc_q + 8'd1;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DONE: begin
        // The controller may still show our grant here; it must not restart anything.
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    busy_d    = (state_d != IDLE);
    granted_d = (state_d == XFER);
    starved_d = (wait_d >= WAIT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      pc_q      <= 8'd0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      granted_q <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      pc_q      <= pc_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      granted_q <= granted_d;
      starved_q <= starved_d;
    end
  end

  assign req         = req_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign granted     = granted_q;
  assign remaining   = rem_q;
  assign preempt_cnt = pc_q;
  assign starved     = starved_q;

endmodule

// File: tb/tb_access_requester.sv
// Directed bench: a vector table on an M2 requester plus hand sequences on an M3
// requester (preemption, starvation, async reset).
module tb_access_requester;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       s1, ab1, s2, ab2;
  logic [7:0] l1, l2;
  logic [1:0] a1, a2;
  logic       req1, done1, busy1, gr1, st1;
  logic       req2, done2, busy2, gr2, st2;
  logic [7:0] rem1, pc1, rem2, pc2;

  access_requester #(.MODULE_ID(1), .LEN_W(8), .STARVE_LIMIT(64)) u_m2 (
    .clk(clk), .reset(reset), .start(s1), .len(l1), .abort(ab1), .accmodule(a1),
    .req(req1), .done(done1), .busy(busy1), .granted(gr1), .remaining(rem1),
    .preempt_cnt(pc1), .starved(st1));

  access_requester #(.MODULE_ID(2), .LEN_W(8), .STARVE_LIMIT(4)) u_m3 (
    .clk(clk), .reset(reset), .start(s2), .len(l2), .abort(ab2), .accmodule(a2),
    .req(req2), .done(done2), .busy(busy2), .granted(gr2), .remaining(rem2),
    .preempt_cnt(pc2), .starved(st2));

  typedef struct {
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic [1:0] acc;
    logic [7:0] e_rem;
    logic [7:0] e_pc;
    logic [4:0] e_flags;  // {req, done, busy, granted, starved}
  } vec_t;

  vec_t vecs[20];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step2(input logic s, input logic [7:0] l, input logic ab, input logic [1:0] a);
    s2 = s; l2 = l; ab2 = ab; a2 = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s1 = 0; l1 = 0; ab1 = 0; a1 = 0;
    s2 = 0; l2 = 0; ab2 = 0; a2 = 0;

    vecs[0]  = '{1'b1, 8'd3, 1'b0, 2'd0, 8'd3, 8'd0, 5'b10100};
    vecs[1]  = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd2, 8'd0, 5'b10110};
    vecs[2]  = '{1'b1, 8'd9, 1'b0, 2'd2, 8'd1, 8'd0, 5'b10110};
    vecs[3]  = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd0, 8'd0, 5'b01100};
    vecs[4]  = '{1'b1, 8'd5, 1'b0, 2'd2, 8'd0, 8'd0, 5'b00000};
    vecs[5]  = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd0, 8'd0, 5'b00000};
    vecs[6]  = '{1'b1, 8'd0, 1'b0, 2'd0, 8'd0, 8'd0, 5'b00000};
    vecs[7]  = '{1'b1, 8'd2, 1'b0, 2'd3, 8'd2, 8'd0, 5'b10100};
    vecs[8]  = '{1'b0, 8'd0, 1'b0, 2'd3, 8'd2, 8'd0, 5'b10100};
    vecs[9]  = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd1, 8'd0, 5'b10110};
    vecs[10] = '{1'b0, 8'd0, 1'b0, 2'd1, 8'd1, 8'd1, 5'b10100};
    vecs[11] = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd0, 8'd1, 5'b01100};
    vecs[12] = '{1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 8'd1, 5'b00000};
    vecs[13] = '{1'b1, 8'd4, 1'b0, 2'd2, 8'd4, 8'd0, 5'b10100};
    vecs[14] = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd3, 8'd0, 5'b10110};
    vecs[15] = '{1'b0, 8'd0, 1'b1, 2'd2, 8'd0, 8'd0, 5'b00000};
    vecs[16] = '{1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 8'd0, 5'b00000};
    vecs[17] = '{1'b1, 8'd1, 1'b0, 2'd0, 8'd1, 8'd0, 5'b10100};
    vecs[18] = '{1'b0, 8'd0, 1'b0, 2'd2, 8'd0, 8'd0, 5'b01100};
    vecs[19] = '{1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 8'd0, 5'b00000};

    #12;
    chk("reset_m2", {11'd0, rem1, pc1, req1, done1, busy1, gr1, st1}, 32'd0);
    chk("reset_m3", {11'd0, rem2, pc2, req2, done2, busy2, gr2, st2}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      s1 = vecs[i].start; l1 = vecs[i].len; ab1 = vecs[i].abort; a1 = vecs[i].acc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {11'd0, rem1, pc1, req1, done1, busy1, gr1, st1},
          {11'd0, vecs[i].e_rem, vecs[i].e_pc, vecs[i].e_flags});
    end
    s1 = 0; l1 = 0; ab1 = 0; a1 = 0;

    // preemption: two beats, M1 takes over for three cycles, then resume
    step2(1, 8'd5, 0, 2'd0);
    chk("pre_req", {rem2, 7'd0, req2}, {8'd5, 8'd1});
    step2(0, 0, 0, 2'd3);
    chk("pre_beat1", {rem2, 6'd0, gr2, req2}, {8'd4, 8'd3});
    step2(0, 0, 0, 2'd3);
    chk("pre_beat2", {rem2, 6'd0, gr2, req2}, {8'd3, 8'd3});
    step2(0, 0, 0, 2'd1);
    chk("pre_susp", {rem2, pc2, req2, busy2, gr2}, {8'd3, 8'd1, 3'b110});
    step2(0, 0, 0, 2'd1);
    step2(0, 0, 0, 2'd1);
    chk("pre_hold", {rem2, pc2, req2, gr2, st2}, {8'd3, 8'd1, 3'b100});
    step2(0, 0, 0, 2'd3);
    chk("pre_resume", {rem2, 7'd0, gr2}, {8'd2, 8'd1});
    step2(0, 0, 0, 2'd3);
    chk("pre_beat4", rem2, 8'd1);
    step2(0, 0, 0, 2'd3);
    chk("pre_done", {rem2, pc2, req2, done2}, {8'd0, 8'd1, 2'b01});
    step2(0, 0, 0, 2'd0);
    chk("pre_idle", {pc2, done2, busy2}, {8'd1, 2'b00});

    // starvation with limit 4, then a single-beat grant
    step2(1, 8'd1, 0, 2'd0);
    chk("stv_req", {req2, st2}, 2'b10);
    for (int k = 1; k <= 5; k++) begin
      step2(0, 0, 0, 2'd0);
      chk($sformatf("stv_wait%0d", k), st2, (k >= 4) ? 1'b1 : 1'b0);
    end
    step2(0, 0, 0, 2'd3);
    chk("stv_grant", {rem2, st2, done2, req2}, {8'd0, 3'b010});
    step2(0, 0, 0, 2'd0);
    chk("stv_after", {done2, busy2}, 2'b00);

    // asynchronous reset while suspended
    step2(1, 8'd4, 0, 2'd0);
    step2(0, 0, 0, 2'd3);
    step2(0, 0, 0, 2'd0);
    chk("rst_pre_susp", {rem2, pc2, req2, gr2}, {8'd3, 8'd1, 2'b10});
    #2 reset = 1'b0;
    #1;
    chk("rst_async", {rem2, pc2, req2, busy2, done2}, {8'd0, 8'd0, 3'b000});
    #3 reset = 1'b1;
    step2(1, 8'd2, 0, 2'd0);
    chk("rst_restart", {rem2, req2}, {8'd2, 1'b1});
    step2(0, 0, 0, 2'd3);
    chk("rst_beat", rem2, 8'd1);
    step2(0, 0, 0, 2'd3);
    chk("rst_done", {rem2, done2, req2}, {8'd0, 2'b10});
    step2(0, 0, 0, 2'd0);
    chk("rst_idle", {done2, busy2}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
